// File: rtl/spart_echo_ctrl.sv
// SPART echo controller: programs the baud divisor, then echoes every
// received byte back out through a 4-entry FIFO.
module spart_echo_ctrl #(
    parameter logic [15:0] DIV_4800  = 16'h028A,
    parameter logic [15:0] DIV_9600  = 16'h0144,
    parameter logic [15:0] DIV_19200 = 16'h00A1,
    parameter logic [15:0] DIV_38400 = 16'h0050
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       cfg_done,
    output logic [2:0] fifo_cnt
);

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cfg_sel;
    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [15:0] div_live;
    logic [15:0] div_held;
    logic [7:0]  dout;
    logic        drive;
    logic        push;
    logic        pop;

    function automatic logic [15:0] div_of(input logic [1:0] sel);
        logic [15:0] d;
        unique case (sel)
            2'b00: d = DIV_4800;
            2'b01: d = DIV_9600;
            2'b10: d = DIV_19200;
            2'b11: d = DIV_38400;
        endcase
        return d;
    endfunction

    // CFG_LO uses the live select; CFG_HI uses the one captured in CFG_LO
    assign div_live = div_of(br_cfg);
    assign div_held = div_of(cfg_sel);

    assign push     = (state == RD);
    assign pop      = (state == WR);
    assign fifo_cnt = count;
    assign databus  = drive ? dout : 8'hzz;

    always_comb begin
        state_nx = state;
        unique case (state)
            CFG_LO: state_nx = CFG_HI;
            CFG_HI: state_nx = GAP;
            RD:     state_nx = GAP;
            WR:     state_nx = GAP;
            GAP:    state_nx = IDLE;
            IDLE: begin
                if (br_cfg != cfg_sel)
                    state_nx = CFG_LO;
                else if (rda && count < 3'd4)
                    state_nx = RD;
                else if (tbr && count != 3'd0)
                    state_nx = WR;
            end
            default: state_nx = CFG_LO;
        endcase
    end

    // Bus is forced idle while reset is held
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        drive  = 1'b0;
        dout   = 8'h00;
        if (!rst) begin
            unique case (state)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b10;
                    drive  = 1'b1;
                    dout   = div_live[7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b11;
                    drive  = 1'b1;
                    dout   = div_held[15:8];
                end
                RD: begin
                    iocs = 1'b1;
                end
                WR: begin
                    iocs  = 1'b1;
                    iorw  = 1'b0;
                    drive = 1'b1;
                    dout  = mem[rd_ptr];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CFG_LO;
            cfg_sel  <= 2'b00;
            cfg_done <= 1'b0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
        end else begin
            state <= state_nx;
            if (state == CFG_LO)
                cfg_sel <= br_cfg;
            if (state == CFG_HI)
                cfg_done <= 1'b1;
            else if (state == IDLE && state_nx == CFG_LO)
                cfg_done <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            if (push)
                count <= count + 3'd1;
            else if (pop)
                count <= count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= databus;
    end

endmodule
